wb_forward_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_regfile.sv | 35 +++
 rtl/wb_forward_unit.sv | 96 +++++++++
 tb/tb_wb_forward_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, types and helpers for the pipelined ALU writeback/forwarding slice.
package alu_pkg;

  // Datapath geometry
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NREG = 2 ** AW;

  // Bit positions inside a 4-bit nzcv vector
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  // Opcodes at or above this value only update flags and never write a register
  localparam logic [3:0] OPC_FLAGS_ONLY_MIN = 4'b1000;

  // One instruction held in the writeback pipeline register
  typedef struct packed {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic [3:0]    nzcv;
  } wb_entry_t;

  // True when the opcode belongs to the compare/test class
  function automatic logic is_flags_only(input logic [3:0] opcode);
    return opcode >= OPC_FLAGS_ONLY_MIN;
  endfunction

  // True when a valid register-writing producer targets the given source register
  function automatic logic addr_hit(input logic          valid,
                                    input logic          we,
                                    input logic [AW-1:0] rd,
                                    input logic [AW-1:0] rs);
    return valid & we & (rd == rs);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: one synchronous write port, two asynchronous read ports.
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] mem [NREG];

  // Clear every entry on reset, otherwise write the committed result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Raw reads; same-cycle write visibility is handled by the bypass in the parent
  always_comb begin
    rdata1 = mem[raddr1];
    rdata2 = mem[raddr2];
  end

endmodule

// File: rtl/wb_forward_unit.sv
// Writeback register, register-file/flag commit and operand/flag bypass back to execute.
module wb_forward_unit
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_is_write,
  input  logic [3:0]    ex_nzcv,
  input  logic [AW-1:0] ex_rd,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] dep,
  output logic          depi,
  output logic [3:0]    nzcv_old,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data
);

  wb_entry_t     wb_q;
  logic          wb_valid_q;
  logic [3:0]    flag_q;
  logic [DW-1:0] rf_rdata1;
  logic [DW-1:0] rf_rdata2;
  logic          rf_we;

  assign rf_we = wb_valid_q & wb_q.we;

  alu_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (wb_q.rd),
    .wdata  (wb_q.data),
    .raddr1 (id_rs1),
    .raddr2 (id_rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // Capture the execute result; fields hold while execute is idle so only valid drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
    end else begin
      wb_valid_q <= ex_valid;
      if (ex_valid) begin
        wb_q.we   <= ex_is_write;
        wb_q.rd   <= ex_rd;
        wb_q.data <= ex_result;
        wb_q.nzcv <= ex_nzcv;
      end
    end
  end

  // Flags retire for every valid instruction, compare/test class included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 4'b0000;
    end else if (wb_valid_q) begin
      flag_q <= wb_q.nzcv;
    end
  end

  // Operand bypass: execute result (port 1 only), then WB entry, then register file
  always_comb begin
    rdata1 = rf_rdata1;
    rdata2 = rf_rdata2;
    if (addr_hit(ex_valid, ex_is_write, ex_rd, id_rs1)) begin
      rdata1 = ex_result;
    end else if (addr_hit(wb_valid_q, wb_q.we, wb_q.rd, id_rs1)) begin
      rdata1 = wb_q.data;
    end
    if (addr_hit(wb_valid_q, wb_q.we, wb_q.rd, id_rs2)) begin
      rdata2 = wb_q.data;
    end
  end

  // Operand-2 forward from execute plus youngest-first flag bypass
  always_comb begin
    depi     = id_valid & addr_hit(ex_valid, ex_is_write, ex_rd, id_rs2);
    dep      = depi ? ex_result : '0;
    nzcv_old = ex_valid ? ex_nzcv : (wb_valid_q ? wb_q.nzcv : flag_q);
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_q.rd;
  assign wb_data  = wb_q.data;

endmodule

// File: tb/tb_wb_forward_unit.sv
// Self-checking bench for wb_forward_unit: directed scenarios plus an every-cycle model compare.
module tb_wb_forward_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic        ex_is_write;
  logic [3:0]  ex_nzcv;
  logic [3:0]  ex_rd;
  logic        id_valid;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] dep;
  logic        depi;
  logic [3:0]  nzcv_old;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_pass   = 0;

  wb_forward_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_result   (ex_result),
    .ex_is_write (ex_is_write),
    .ex_nzcv     (ex_nzcv),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .dep         (dep),
    .depi        (depi),
    .nzcv_old    (nzcv_old),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: architectural state plus the list of instructions not yet retired
  typedef struct {
    logic        we;
    logic [3:0]  rd;
    logic [31:0] data;
    logic [3:0]  nz;
  } instr_t;

  logic [31:0] arch_rf [16];
  logic [3:0]  arch_flags;
  instr_t      inflight [$];
  instr_t      last_cap;
  instr_t      tmp_instr;

  // Each edge retires everything in flight, then the presented instruction enters flight
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) arch_rf[i] = 32'h0;
      arch_flags = 4'h0;
      inflight.delete();
      last_cap = '{we: 1'b0, rd: 4'h0, data: 32'h0, nz: 4'h0};
    end else begin
      while (inflight.size() > 0) begin
        tmp_instr = inflight.pop_front();
        if (tmp_instr.we) arch_rf[tmp_instr.rd] = tmp_instr.data;
        arch_flags = tmp_instr.nz;
      end
      if (ex_valid) begin
        tmp_instr = '{we: ex_is_write, rd: ex_rd, data: ex_result, nz: ex_nzcv};
        inflight.push_back(tmp_instr);
        last_cap = tmp_instr;
      end
    end
  end

  // Youngest value of a register as seen by decode, optionally including the execute stage
  function automatic logic [31:0] model_read(input logic [3:0] rs, input logic with_ex);
    if (with_ex && ex_valid && ex_is_write && ex_rd == rs) return ex_result;
    for (int i = inflight.size() - 1; i >= 0; i--) begin
      if (inflight[i].we && inflight[i].rd == rs) return inflight[i].data;
    end
    return arch_rf[rs];
  endfunction

  function automatic logic [3:0] model_flags();
    if (ex_valid) return ex_nzcv;
    if (inflight.size() > 0) return inflight[inflight.size() - 1].nz;
    return arch_flags;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic [3:0] rd, input logic [31:0] res,
                               input logic we, input logic [3:0] nz,
                               input logic idv, input logic [3:0] rs1, input logic [3:0] rs2);
    ex_valid    = ev;
    ex_rd       = rd;
    ex_result   = res;
    ex_is_write = we;
    ex_nzcv     = nz;
    id_valid    = idv;
    id_rs1      = rs1;
    id_rs2      = rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [31:0] exp_dep;
    logic        exp_depi;
    exp_depi = id_valid && ex_valid && ex_is_write && (ex_rd == id_rs2);
    exp_dep  = exp_depi ? ex_result : 32'h0;
    checkOutput("model_rdata1", rdata1, model_read(id_rs1, 1'b1));
    checkOutput("model_rdata2", rdata2, model_read(id_rs2, 1'b0));
    checkOutput("model_depi", {31'h0, depi}, {31'h0, exp_depi});
    checkOutput("model_dep", dep, exp_dep);
    checkOutput("model_nzcv_old", {28'h0, nzcv_old}, {28'h0, model_flags()});
    checkOutput("model_wb_valid", {31'h0, wb_valid}, {31'h0, (inflight.size() > 0)});
    checkOutput("model_wb_rd", {28'h0, wb_rd}, {28'h0, last_cap.rd});
    checkOutput("model_wb_data", wb_data, last_cap.data);
  end

  typedef struct {
    logic        we;
    logic [3:0]  rd;
    logic [31:0] res;
    logic [3:0]  nz;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
  } vec_t;

  vec_t vecs [8];

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("reset_wb_valid", {31'h0, wb_valid}, 32'h0);
    checkOutput("reset_nzcv_old", {28'h0, nzcv_old}, 32'h0);
    checkOutput("reset_depi", {31'h0, depi}, 32'h0);
    checkOutput("reset_wb_data", wb_data, 32'h0);

    // Commit: rd=3, A5, flags 0010; architectural after two edges
    tick();
    applyStimulus(1'b1, 4'd3, 32'h0000_00A5, 1'b1, 4'b0010, 1'b0, 4'd0, 4'd0);
    tick();
    idle();
    tick();
    id_rs1 = 4'd3;
    #2;
    checkOutput("commit_wb_retired", {31'h0, wb_valid}, 32'h0);
    checkOutput("commit_rf3", rdata1, 32'h0000_00A5);
    checkOutput("commit_flags", {28'h0, nzcv_old}, 32'h2);

    // Forward to operand 2 from execute, then same with is_write=0
    applyStimulus(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b1, 4'b0000, 1'b1, 4'd0, 4'd5);
    #2;
    checkOutput("fwd_depi", {31'h0, depi}, 32'h1);
    checkOutput("fwd_dep", dep, 32'hDEAD_BEEF);
    checkOutput("fwd_rdata2_no_ex", rdata2, 32'h0);
    ex_is_write = 1'b0;
    #2;
    checkOutput("fwd_nowrite_depi", {31'h0, depi}, 32'h0);
    checkOutput("fwd_nowrite_dep", dep, 32'h0);
    tick();

    // WB bypass: rf[7]=1 committed, WB holds 7<-2
    applyStimulus(1'b1, 4'd7, 32'h1, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0);
    tick();
    idle();
    tick();
    applyStimulus(1'b1, 4'd7, 32'h2, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'b0000, 1'b1, 4'd7, 4'd7);
    #2;
    checkOutput("wbbyp_rdata1", rdata1, 32'h2);
    checkOutput("wbbyp_rdata2", rdata2, 32'h2);
    tick();
    #2;
    checkOutput("wbbyp_rf7", rdata1, 32'h2);
    checkOutput("wbbyp_retired", {31'h0, wb_valid}, 32'h0);

    // Flags priority: flag_q=0000, WB=1000, EX=0011
    applyStimulus(1'b1, 4'd0, 32'h0, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd0);
    tick();
    idle();
    tick();
    applyStimulus(1'b1, 4'd0, 32'h0, 1'b0, 4'b1000, 1'b0, 4'd0, 4'd0);
    tick();
    applyStimulus(1'b1, 4'd0, 32'h0, 1'b0, 4'b0011, 1'b0, 4'd0, 4'd0);
    #2;
    checkOutput("flags_ex", {28'h0, nzcv_old}, 32'h3);
    ex_valid = 1'b0;
    #2;
    checkOutput("flags_wb", {28'h0, nzcv_old}, 32'h8);
    tick();

    // Flags-only instruction leaves rf[2] untouched
    applyStimulus(1'b1, 4'd2, 32'h55, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0);
    tick();
    idle();
    tick();
    applyStimulus(1'b1, 4'd2, 32'hFFFF_FFFF, 1'b0, 4'b0100, 1'b1, 4'd2, 4'd2);
    #2;
    checkOutput("flagsonly_no_exbyp", rdata1, 32'h55);
    checkOutput("flagsonly_depi", {31'h0, depi}, 32'h0);
    tick();
    idle();
    tick();
    id_rs1 = 4'd2;
    #2;
    checkOutput("flagsonly_rf2", rdata1, 32'h55);
    checkOutput("flagsonly_flags", {28'h0, nzcv_old}, 32'h4);

    // Boundary registers 0 and 15, back-to-back writers
    vecs[0] = '{we: 1'b1, rd: 4'd0,  res: 32'hCAFE_0000, nz: 4'b0001, rs1: 4'd0,  rs2: 4'd15};
    vecs[1] = '{we: 1'b1, rd: 4'd15, res: 32'h1234_5678, nz: 4'b1001, rs1: 4'd0,  rs2: 4'd15};
    vecs[2] = '{we: 1'b1, rd: 4'd15, res: 32'h8765_4321, nz: 4'b0110, rs1: 4'd15, rs2: 4'd15};
    vecs[3] = '{we: 1'b0, rd: 4'd0,  res: 32'h0BAD_0BAD, nz: 4'b1111, rs1: 4'd0,  rs2: 4'd0};
    vecs[4] = '{we: 1'b1, rd: 4'd8,  res: 32'hFFFF_0001, nz: 4'b0010, rs1: 4'd15, rs2: 4'd8};
    vecs[5] = '{we: 1'b1, rd: 4'd8,  res: 32'h0000_0002, nz: 4'b0000, rs1: 4'd8,  rs2: 4'd8};
    vecs[6] = '{we: 1'b0, rd: 4'd8,  res: 32'h0000_0003, nz: 4'b1100, rs1: 4'd8,  rs2: 4'd8};
    vecs[7] = '{we: 1'b1, rd: 4'd1,  res: 32'hA5A5_A5A5, nz: 4'b0101, rs1: 4'd8,  rs2: 4'd1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].rd, vecs[i].res, vecs[i].we, vecs[i].nz, 1'b1, vecs[i].rs1, vecs[i].rs2);
      tick();
    end
    idle();
    tick();
    id_rs1 = 4'd0;
    id_rs2 = 4'd15;
    #2;
    checkOutput("boundary_r0", rdata1, 32'hCAFE_0000);
    checkOutput("boundary_r15", rdata2, 32'h8765_4321);
    id_rs1 = 4'd8;
    #2;
    checkOutput("boundary_r8", rdata1, 32'h0000_0002);
    checkOutput("boundary_flags", {28'h0, nzcv_old}, 32'h5);

    // Reset mid-run with a pending WB entry
    applyStimulus(1'b1, 4'd9, 32'h99, 1'b1, 4'b1111, 1'b0, 4'd0, 4'd0);
    tick();
    checkOutput("prereset_wb_valid", {31'h0, wb_valid}, 32'h1);
    ex_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_wb_valid", {31'h0, wb_valid}, 32'h0);
    checkOutput("midreset_nzcv", {28'h0, nzcv_old}, 32'h0);
    for (int r = 0; r < 16; r++) begin
      id_rs1 = r[3:0];
      #0.2;
      checkOutput("midreset_rdata1", rdata1, 32'h0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    id_rs1 = 4'd9;
    #2;
    checkOutput("postreset_rf9", rdata1, 32'h0);
    checkOutput("postreset_wb_valid", {31'h0, wb_valid}, 32'h0);

    tick();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
